// File: rtl/pri3to4_dec_seq.sv
// Sequential decoder for {any, idx[1:0]} priority codes: buffers codes in a small FIFO,
// rebuilds the one-hot request word and shows it for at least HOLD_CYC cycles before handoff.
module pri3to4_dec_seq #(
    parameter int DEPTH    = 2,
    parameter int HOLD_CYC = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_code,
    output logic [3:0]       o_y,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [CNT_W-1:0] o_null_cnt,
    output logic             o_busy
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD_CYC - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  NULL_MAX  = '1;

    typedef enum logic {
        S_IDLE,
        S_SHOW
    } state_t;

    logic [2:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_y;
    logic [HCNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0]  r_null_cnt;

    logic       w_push;
    logic       w_pop;
    logic       w_clear;
    logic       w_xfer;
    logic       w_fifo_ne;
    logic [2:0] w_head;

    function automatic logic [3:0] f_decode(input logic [2:0] c);
        f_decode = c[2] ? (4'b0001 << c[1:0]) : 4'b0000;
    endfunction

    // Ready comes only from the registered fill level, so no combinational in->out path exists.
    assign o_in_ready = (r_count < FIFO_FULL);
    assign w_push     = i_in_valid && o_in_ready;
    assign w_fifo_ne  = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_xfer     = (r_state == S_SHOW) && i_out_ready && (r_hcnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_ne) begin
                    w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (w_xfer && !w_fifo_ne) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A transfer with more words queued reloads y on the same edge, so the stream has no bubble.
    always_comb begin
        w_pop   = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = w_fifo_ne;
            end
            S_SHOW: begin
                if (w_xfer) begin
                    w_pop   = w_fifo_ne;
                    w_clear = !w_fifo_ne;
                end
            end
            default: begin
                w_pop   = 1'b0;
                w_clear = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_hcnt <= '0;
        end else begin
            if (w_pop) begin
                r_y    <= f_decode(w_head);
                r_hcnt <= HCNT_LOAD;
            end else begin
                if (w_clear) begin
                    r_y <= '0;
                end
                if ((r_state == S_SHOW) && (r_hcnt != '0)) begin
                    r_hcnt <= r_hcnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_null_cnt <= '0;
        end else if (w_push && !i_code[2] && (r_null_cnt != NULL_MAX)) begin
            r_null_cnt <= r_null_cnt + 1'b1;
        end
    end

    assign o_y         = r_y;
    assign o_out_valid = (r_state == S_SHOW);
    assign o_null_cnt  = r_null_cnt;
    assign o_busy      = w_fifo_ne | o_out_valid;

endmodule

// File: tb/tb_pri3to4_dec_seq.sv
// Bench for pri3to4_dec_seq: three instances (default, long hold, narrow null counter)
// checked against a queue-based model of the decoded output stream.
module tb_pri3to4_dec_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [2:0] a_code;
    logic [3:0] a_y;
    logic [7:0] a_null_cnt;

    logic       h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_busy;
    logic [2:0] h_code;
    logic [3:0] h_y;
    logic [7:0] h_null_cnt;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [2:0] s_code;
    logic [3:0] s_y;
    logic [1:0] s_null_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int         model_null = 0;

    pri3to4_dec_seq #(.DEPTH(2), .HOLD_CYC(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_code(a_code),
        .o_y(a_y), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
        .o_null_cnt(a_null_cnt), .o_busy(a_busy)
    );

    pri3to4_dec_seq #(.DEPTH(2), .HOLD_CYC(3), .CNT_W(8)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(h_in_valid), .o_in_ready(h_in_ready), .i_code(h_code),
        .o_y(h_y), .o_out_valid(h_out_valid), .i_out_ready(h_out_ready),
        .o_null_cnt(h_null_cnt), .o_busy(h_busy)
    );

    pri3to4_dec_seq #(.DEPTH(2), .HOLD_CYC(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(s_in_valid), .o_in_ready(s_in_ready), .i_code(s_code),
        .o_y(s_y), .o_out_valid(s_out_valid), .i_out_ready(s_out_ready),
        .o_null_cnt(s_null_cnt), .o_busy(s_busy)
    );

    // One-hot reconstruction from the code's meaning: bit number idx set when any is high.
    function automatic logic [3:0] model_dec(input logic [2:0] c);
        if (c[2]) return 4'(2 ** int'(c[1:0]));
        return 4'b0000;
    endfunction

    // Records every accepted code (as its expected word) and every word the consumer takes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(model_dec(a_code));
                if (!a_code[2] && model_null < 255) model_null++;
            end
            if (a_out_valid && a_out_ready) obs_q.push_back(a_y);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset();
        a_in_valid = 0; a_code = 0; a_out_ready = 0;
        h_in_valid = 0; h_code = 0; h_out_ready = 0;
        s_in_valid = 0; s_code = 0; s_out_ready = 0;
        rst_n = 0;
        exp_q.delete();
        obs_q.delete();
        model_null = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests_run++;
        if (a_y !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_y: got %b expected 0000", a_y); end
        tests_run++;
        if (a_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        tests_run++;
        if (a_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        tests_run++;
        if (a_null_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_null_cnt: got %0d expected 0", a_null_cnt); end
        tests_run++;
        if (a_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", a_busy); end

        @(posedge clk); #1;
        a_out_ready = 0;
        a_in_valid = 1; a_code = 3'b111;
        @(posedge clk); #1 a_code = 3'b000;
        @(posedge clk); #1 a_code = 3'b100;
        @(posedge clk); #1 a_in_valid = 0;
        @(negedge clk);
        tests_run++;
        if (a_y !== 4'b1000 || a_out_valid !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL prereset_show: got y=%b v=%b expected y=1000 v=1", a_y, a_out_valid);
        end
        tests_run++;
        if (a_in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL prereset_full: got in_ready=%b expected 0", a_in_ready); end
        tests_run++;
        if (a_null_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL prereset_null_cnt: got %0d expected 1", a_null_cnt); end

        #2 rst_n = 0;
        #1;
        tests_run++;
        if (a_y !== 4'b0000 || a_out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL midreset_out: got y=%b v=%b expected y=0000 v=0", a_y, a_out_valid);
        end
        tests_run++;
        if (a_null_cnt !== 8'd0 || a_busy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL midreset_state: got null=%0d busy=%b expected null=0 busy=0", a_null_cnt, a_busy);
        end
        #1 rst_n = 1;
        @(negedge clk);
        tests_run++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL postreset: got rdy=%b v=%b busy=%b expected rdy=1 v=0 busy=0", a_in_ready, a_out_valid, a_busy);
        end
    endtask

    task automatic test_decode_sweep();
        logic [2:0] codes [5];
        logic [3:0] want  [5];
        codes = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
        want  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        apply_reset();
        a_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1; a_code = codes[i];
            @(posedge clk); #1;
        end
        a_in_valid = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (obs_q.size() >= 5 && !a_busy) break;
        end
        tests_run++;
        if (obs_q.size() != 5) begin tests_failed++; $display("[TB] FAIL sweep_count: got %0d words expected 5", obs_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < obs_q.size()) begin
                tests_run++;
                if (obs_q[i] !== want[i]) begin
                    tests_failed++; $display("[TB] FAIL sweep_word%0d: got %b expected %b", i, obs_q[i], want[i]);
                end
            end
        end
        tests_run++;
        if (a_null_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL sweep_null_cnt: got %0d expected 1", a_null_cnt); end
    endtask

    task automatic test_hold();
        int   first_cyc = -1;
        int   shown     = 0;
        int   rises     = 0;
        logic prev      = 1'b0;
        apply_reset();
        h_out_ready = 1;
        h_in_valid = 1; h_code = 3'b110;
        @(posedge clk); #1 h_in_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (h_out_valid && h_y === 4'b0100) begin
                if (first_cyc < 0) first_cyc = c;
                shown++;
            end
            if (h_out_valid && !prev) rises++;
            prev = h_out_valid;
        end
        tests_run++;
        if (shown != 3) begin tests_failed++; $display("[TB] FAIL hold_cycles: got %0d expected 3", shown); end
        tests_run++;
        if (first_cyc != 1) begin tests_failed++; $display("[TB] FAIL hold_latency: got cycle %0d expected 1", first_cyc); end
        tests_run++;
        if (rises != 1) begin tests_failed++; $display("[TB] FAIL hold_single_word: got %0d valid windows expected 1", rises); end
        tests_run++;
        if (h_y !== 4'b0000 || h_out_valid !== 1'b0 || h_busy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL hold_after: got y=%b v=%b busy=%b expected 0000 0 0", h_y, h_out_valid, h_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] want [3];
        want = '{4'b0010, 4'b1000, 4'b0001};
        apply_reset();
        a_out_ready = 0;
        a_in_valid = 1; a_code = 3'b101;
        @(posedge clk); #1 a_code = 3'b111;
        @(posedge clk); #1 a_code = 3'b100;
        @(posedge clk); #1 a_code = 3'b000;
        @(negedge clk);
        tests_run++;
        if (a_y !== 4'b0010 || a_out_valid !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL bp_first: got y=%b v=%b expected y=0010 v=1", a_y, a_out_valid);
        end
        tests_run++;
        if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL bp_full: got rdy=%b busy=%b expected rdy=0 busy=1", a_in_ready, a_busy);
        end
        @(posedge clk); #1;
        @(posedge clk); #1 a_code = 3'b100;
        @(posedge clk); #1 a_in_valid = 0;
        @(negedge clk);
        tests_run++;
        if (a_null_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL bp_drop_null: got %0d expected 0", a_null_cnt); end
        tests_run++;
        if (a_y !== 4'b0010) begin tests_failed++; $display("[TB] FAIL bp_stable_y: got %b expected 0010", a_y); end
        @(posedge clk); #1 a_out_ready = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (obs_q.size() >= 3 && !a_busy) break;
        end
        tests_run++;
        if (obs_q.size() != 3) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d words expected 3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < obs_q.size()) begin
                tests_run++;
                if (obs_q[i] !== want[i]) begin
                    tests_failed++; $display("[TB] FAIL bp_word%0d: got %b expected %b", i, obs_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   rises = 0;
        int   vcyc  = 0;
        logic prev  = 1'b0;
        apply_reset();
        a_out_ready = 1;
        for (int c = 0; c < 40; c++) begin
            if (c < 8) begin
                a_in_valid = 1;
                a_code = 3'($urandom_range(0, 7));
            end else begin
                a_in_valid = 0;
            end
            @(negedge clk);
            if (a_out_valid && !prev) rises++;
            if (a_out_valid) vcyc++;
            prev = a_out_valid;
            @(posedge clk); #1;
        end
        tests_run++;
        if (rises != 1 || vcyc != 8) begin
            tests_failed++; $display("[TB] FAIL b2b_bubble: got %0d windows %0d valid cycles expected 1 and 8", rises, vcyc);
        end
        tests_run++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            tests_failed++; $display("[TB] FAIL b2b_count: got %0d out %0d in expected 8 and 8", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < obs_q.size() && i < exp_q.size()) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    tests_failed++; $display("[TB] FAIL b2b_word%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (int'(a_null_cnt) != model_null) begin
            tests_failed++; $display("[TB] FAIL b2b_null_cnt: got %0d expected %0d", a_null_cnt, model_null);
        end
    endtask

    task automatic test_random_flow();
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_code      = 3'($urandom_range(0, 7));
            a_out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        a_in_valid  = 0;
        a_out_ready = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!a_busy) break;
        end
        tests_run++;
        if (a_busy !== 1'b0 || obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL rand_drain: got busy=%b %0d words out expected busy=0 %0d words", a_busy, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            if (i < exp_q.size()) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    tests_failed++; $display("[TB] FAIL rand_word%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (int'(a_null_cnt) != model_null) begin
            tests_failed++; $display("[TB] FAIL rand_null_cnt: got %0d expected %0d", a_null_cnt, model_null);
        end
    endtask

    task automatic test_saturation();
        int want;
        apply_reset();
        s_out_ready = 1;
        for (int k = 1; k <= 5; k++) begin
            s_in_valid = 1;
            s_code = {1'b0, 2'($urandom_range(0, 3))};
            @(posedge clk); #1;
            @(negedge clk);
            want = (k < 3) ? k : 3;
            tests_run++;
            if (int'(s_null_cnt) != want) begin
                tests_failed++; $display("[TB] FAIL sat_null_cnt%0d: got %0d expected %0d", k, s_null_cnt, want);
            end
        end
        s_in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_hold();
        test_backpressure();
        test_back_to_back();
        test_random_flow();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
